tile_move_arbiter: RTL

Arbitrates the shared tile grid between player A and player B. Each player raises a level move request with a direction. The block checks the request against grid bounds, the `walkAble` map and the other player's tile, and resolves simultaneous contention round-robin. It owns both players' tile positions, rate-limits moves with a cooldown, and sits between the keyboard decoder and the pixel generator and seven-segment display.

---
 rtl/tile_pkg.sv | 22 ++
 rtl/tile_move_arbiter_if.sv | 36 +++
 rtl/move_target.sv | 63 ++++++
 rtl/tile_move_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared encodings for the tile move arbiter: directions, FSM states, player IDs.
package tile_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic PLAYERA = 1'b0;
    localparam logic PLAYERB = 1'b1;

    localparam int unsigned POS_W = 4;

endpackage

// File: rtl/tile_move_arbiter_if.sv
// Request/response bundle between the keyboard decoder side and the tile move arbiter.
interface tile_move_arbiter_if #(
    parameter int unsigned HMAXTILE = 9,
    parameter int unsigned VMAXTILE = 5
);
    localparam int unsigned NTILES = (HMAXTILE + 1) * (VMAXTILE + 1);

    logic              reqA;
    logic              reqB;
    logic [1:0]        dirA;
    logic [1:0]        dirB;
    logic [NTILES-1:0] walkAble;
    logic [3:0]        curAh;
    logic [3:0]        curAv;
    logic [3:0]        curBh;
    logic [3:0]        curBv;
    logic              grantA;
    logic              grantB;
    logic              denyA;
    logic              denyB;
    logic              prio;
    logic              busy;

    modport master (
        output reqA, reqB, dirA, dirB, walkAble,
        input  curAh, curAv, curBh, curBv,
        input  grantA, grantB, denyA, denyB, prio, busy
    );

    modport slave (
        input  reqA, reqB, dirA, dirB, walkAble,
        output curAh, curAv, curBh, curBv,
        output grantA, grantB, denyA, denyB, prio, busy
    );

endinterface

// File: rtl/move_target.sv
// Combinational target tile and legality check for one player's move request.
module move_target
    import tile_pkg::*;
#(
    parameter int unsigned HMAXTILE = 9,
    parameter int unsigned VMAXTILE = 5,
    localparam int unsigned NTILES = (HMAXTILE + 1) * (VMAXTILE + 1)
) (
    input  logic [3:0]        pos_h,
    input  logic [3:0]        pos_v,
    input  logic [1:0]        dir,
    input  logic [NTILES-1:0] walk_able,
    input  logic [3:0]        other_h,
    input  logic [3:0]        other_v,
    output logic [3:0]        tgt_h,
    output logic [3:0]        tgt_v,
    output logic              legal
);

    localparam int unsigned IDX_W = $clog2(NTILES);
    localparam logic [3:0] HMAX = 4'(HMAXTILE);
    localparam logic [3:0] VMAX = 4'(VMAXTILE);

    logic             in_bounds;
    logic [IDX_W-1:0] idx;

    // An out-of-bounds move leaves the target on the current tile so idx stays in range.
    always_comb begin
        tgt_h     = pos_h;
        tgt_v     = pos_v;
        in_bounds = 1'b0;
        unique case (dir_t'(dir))
            DIR_UP: begin
                if (pos_v != '0) begin
                    tgt_v     = pos_v - 4'd1;
                    in_bounds = 1'b1;
                end
            end
            DIR_DOWN: begin
                if (pos_v < VMAX) begin
                    tgt_v     = pos_v + 4'd1;
                    in_bounds = 1'b1;
                end
            end
            DIR_LEFT: begin
                if (pos_h != '0) begin
                    tgt_h     = pos_h - 4'd1;
                    in_bounds = 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (pos_h < HMAX) begin
                    tgt_h     = pos_h + 4'd1;
                    in_bounds = 1'b1;
                end
            end
        endcase
    end

    assign idx   = IDX_W'(tgt_v) * IDX_W'(HMAXTILE + 1) + IDX_W'(tgt_h);
    assign legal = in_bounds && walk_able[idx] && !((tgt_h == other_h) && (tgt_v == other_v));

endmodule

// File: rtl/tile_move_arbiter.sv
// Owns both players' tile positions; evaluates, arbitrates and rate-limits move requests.
module tile_move_arbiter
    import tile_pkg::*;
#(
    parameter int unsigned HMAXTILE  = 9,
    parameter int unsigned VMAXTILE  = 5,
    parameter int unsigned COOLDOWN  = 5000000,
    parameter int unsigned CD_W      = 23,
    parameter int unsigned A_START_H = 0,
    parameter int unsigned A_START_V = 0,
    parameter int unsigned B_START_H = 9,
    parameter int unsigned B_START_V = 5
) (
    input  logic         clk,
    input  logic         rst,
    tile_move_arbiter_if.slave io
);

    state_t          state;
    logic [CD_W-1:0] cnt;
    logic            lreq_a;
    logic            lreq_b;
    logic [1:0]      ldir_a;
    logic [1:0]      ldir_b;
    logic [3:0]      a_h;
    logic [3:0]      a_v;
    logic [3:0]      b_h;
    logic [3:0]      b_v;
    logic            prio_q;
    logic            busy_q;
    logic            grant_a;
    logic            grant_b;
    logic            deny_a;
    logic            deny_b;

    logic [3:0]      ta_h;
    logic [3:0]      ta_v;
    logic [3:0]      tb_h;
    logic [3:0]      tb_v;
    logic            legal_a;
    logic            legal_b;
    logic            win_a;
    logic            win_b;

    move_target #(.HMAXTILE(HMAXTILE), .VMAXTILE(VMAXTILE)) u_target_a (
        .pos_h    (a_h),
        .pos_v    (a_v),
        .dir      (ldir_a),
        .walk_able(io.walkAble),
        .other_h  (b_h),
        .other_v  (b_v),
        .tgt_h    (ta_h),
        .tgt_v    (ta_v),
        .legal    (legal_a)
    );

    move_target #(.HMAXTILE(HMAXTILE), .VMAXTILE(VMAXTILE)) u_target_b (
        .pos_h    (b_h),
        .pos_v    (b_v),
        .dir      (ldir_b),
        .walk_able(io.walkAble),
        .other_h  (a_h),
        .other_v  (a_v),
        .tgt_h    (tb_h),
        .tgt_v    (tb_v),
        .legal    (legal_b)
    );

    // Two legal requests for the same tile: the prio player keeps it.
    always_comb begin
        win_a = lreq_a && legal_a;
        win_b = lreq_b && legal_b;
        if (win_a && win_b && (ta_h == tb_h) && (ta_v == tb_v)) begin
            if (prio_q == PLAYERA) begin
                win_b = 1'b0;
            end else begin
                win_a = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            lreq_a  <= 1'b0;
            lreq_b  <= 1'b0;
            ldir_a  <= '0;
            ldir_b  <= '0;
            a_h     <= 4'(A_START_H);
            a_v     <= 4'(A_START_V);
            b_h     <= 4'(B_START_H);
            b_v     <= 4'(B_START_V);
            prio_q  <= PLAYERA;
            busy_q  <= 1'b0;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            deny_a  <= 1'b0;
            deny_b  <= 1'b0;
        end else begin
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            deny_a  <= 1'b0;
            deny_b  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (io.reqA || io.reqB) begin
                        lreq_a <= io.reqA;
                        lreq_b <= io.reqB;
                        ldir_a <= io.dirA;
                        ldir_b <= io.dirB;
                        state  <= ST_EVAL;
                        busy_q <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (win_a) begin
                        a_h <= ta_h;
                        a_v <= ta_v;
                    end
                    if (win_b) begin
                        b_h <= tb_h;
                        b_v <= tb_v;
                    end
                    grant_a <= win_a;
                    grant_b <= win_b;
                    deny_a  <= lreq_a && !win_a;
                    deny_b  <= lreq_b && !win_b;
                    if (lreq_a && lreq_b) begin
                        prio_q <= ~prio_q;
                    end
                    cnt   <= CD_W'(COOLDOWN - 1);
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        lreq_a <= 1'b0;
                        lreq_b <= 1'b0;
                    end else begin
                        cnt <= cnt - CD_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.curAh  = a_h;
    assign io.curAv  = a_v;
    assign io.curBh  = b_h;
    assign io.curBv  = b_v;
    assign io.grantA = grant_a;
    assign io.grantB = grant_b;
    assign io.denyA  = deny_a;
    assign io.denyB  = deny_b;
    assign io.prio   = prio_q;
    assign io.busy   = busy_q;

endmodule
